// File: rtl/pong_match_controller.sv
// Pong match controller: serve/rally/point/game-over flow, scores,
// win-by-margin rule and serve direction, all paced by frame ticks.
module pong_match_controller #(
    parameter int SCORE_W     = 8,
    parameter int WIN_SCORE   = 11,
    parameter int WIN_BY      = 2,
    parameter int SERVE_DELAY = 60,
    parameter int POINT_HOLD  = 30,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               pause,
    input  logic [1:0]         score_evt,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic [2:0]         state,
    output logic               ball_enable,
    output logic               serve_pulse,
    output logic               serve_dir,
    output logic [CNT_W-1:0]   countdown,
    output logic               winner_valid,
    output logic               winner
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        RALLY      = 3'd2,
        POINT      = 3'd3,
        GAME_OVER  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]   SERVE_LD = CNT_W'(SERVE_DELAY);
    localparam logic [CNT_W-1:0]   HOLD_LD  = CNT_W'(POINT_HOLD);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [SCORE_W-1:0] SAT      = '1;
    localparam logic [31:0]        WIN_S    = WIN_SCORE;
    localparam logic [31:0]        WIN_M    = WIN_BY;

    state_t             st_q, st_d;
    logic [SCORE_W-1:0] left_q, left_d, right_q, right_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               pulse_q, pulse_d;
    logic               win_q, win_d;
    logic               tick;
    logic               left_wins, right_wins;
    logic [31:0]        l32, r32;

    assign tick = frame_tick & ~pause;
    assign l32  = 32'(left_q);
    assign r32  = 32'(right_q);

    // Lead is only meaningful for the side that is ahead.
    assign left_wins  = (l32 >= WIN_S) && (l32 > r32) && ((l32 - r32) >= WIN_M);
    assign right_wins = (r32 >= WIN_S) && (r32 > l32) && ((r32 - l32) >= WIN_M);

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= IDLE;
            left_q  <= '0;
            right_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b1;
            pulse_q <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            left_q  <= left_d;
            right_q <= right_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pulse_q <= pulse_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        left_d  = left_q;
        right_d = right_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        pulse_d = 1'b0;
        win_d   = win_q;
        case (st_q)
            IDLE: begin
                if (start) begin
                    left_d  = '0;
                    right_d = '0;
                    cnt_d   = SERVE_LD;
                    st_d    = SERVE_WAIT;
                end
            end
            SERVE_WAIT: begin
                if (tick) begin
                    if (cnt_q == CNT_ONE) begin
                        cnt_d   = '0;
                        st_d    = RALLY;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            RALLY: begin
                if (!pause && score_evt != 2'b00) begin
                    st_d  = POINT;
                    cnt_d = HOLD_LD;
                    if (score_evt == 2'b10) begin
                        dir_d = 1'b1;
                        if (left_q != SAT) left_d = left_q + 1'b1;
                    end else if (score_evt == 2'b01) begin
                        dir_d = 1'b0;
                        if (right_q != SAT) right_d = right_q + 1'b1;
                    end
                end
            end
            POINT: begin
                if (tick) begin
                    if (cnt_q == CNT_ONE) begin
                        if (left_wins || right_wins) begin
                            st_d  = GAME_OVER;
                            win_d = left_wins;
                            cnt_d = '0;
                        end else begin
                            st_d  = SERVE_WAIT;
                            cnt_d = SERVE_LD;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            GAME_OVER: begin
                if (start) begin
                    left_d  = '0;
                    right_d = '0;
                    win_d   = 1'b0;
                    dir_d   = 1'b1;
                    cnt_d   = SERVE_LD;
                    st_d    = SERVE_WAIT;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        ball_enable  = (st_q == RALLY) && !pause;
        winner_valid = (st_q == GAME_OVER);
    end

    assign state       = st_q;
    assign score_left  = left_q;
    assign score_right = right_q;
    assign countdown   = cnt_q;
    assign serve_dir   = dir_q;
    assign serve_pulse = pulse_q;
    assign winner      = win_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller: default build plus a
// narrow-score build for saturation.
module tb_pong_match_controller;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       start;
    logic       pause;
    logic [1:0] score_evt;

    logic [7:0] score_left, score_right, countdown;
    logic [2:0] state;
    logic       ball_enable, serve_pulse, serve_dir, winner_valid, winner;

    logic [3:0] score_left2, score_right2;
    logic [7:0] countdown2;
    logic [2:0] state2;
    logic       ball_enable2, serve_pulse2, serve_dir2, winner_valid2, winner2;

    int n_cmp = 0;
    int n_err = 0;

    pong_match_controller dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .pause(pause), .score_evt(score_evt),
        .score_left(score_left), .score_right(score_right), .state(state),
        .ball_enable(ball_enable), .serve_pulse(serve_pulse),
        .serve_dir(serve_dir), .countdown(countdown),
        .winner_valid(winner_valid), .winner(winner)
    );

    pong_match_controller #(.SCORE_W(4), .WIN_SCORE(15), .WIN_BY(20)) dut2 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .pause(pause), .score_evt(score_evt),
        .score_left(score_left2), .score_right(score_right2), .state(state2),
        .ball_enable(ball_enable2), .serve_pulse(serve_pulse2),
        .serve_dir(serve_dir2), .countdown(countdown2),
        .winner_valid(winner_valid2), .winner(winner2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic t, input logic [1:0] e);
        frame_tick = t;
        score_evt  = e;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        score_evt  = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic serve();
        for (int i = 0; i < 60; i++) cyc(1'b1, 2'b00);
    endtask

    task automatic play_point(input logic [1:0] e);
        serve();
        cyc(1'b0, e);
        for (int i = 0; i < 30; i++) cyc(1'b1, 2'b00);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL rst_state got=%0d exp=0", state); end
        n_cmp++; if (score_left !== 8'd0 || score_right !== 8'd0) begin n_err++; $display("FAIL rst_scores got=%0d:%0d exp=0:0", score_left, score_right); end
        n_cmp++; if (countdown !== 8'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", countdown); end
        n_cmp++; if (serve_dir !== 1'b1) begin n_err++; $display("FAIL rst_dir got=%0b exp=1", serve_dir); end
        n_cmp++; if ({ball_enable, serve_pulse, winner_valid, winner} !== 4'b0000) begin n_err++; $display("FAIL rst_flags got=%b exp=0000", {ball_enable, serve_pulse, winner_valid, winner}); end
    endtask

    task automatic test_serve_and_point();
        do_reset();
        do_start();
        n_cmp++; if (state !== 3'd1 || countdown !== 8'd60) begin n_err++; $display("FAIL start_load got=%0d/%0d exp=1/60", state, countdown); end
        for (int i = 0; i < 59; i++) cyc(1'b1, 2'b00);
        n_cmp++; if (state !== 3'd1 || countdown !== 8'd1 || serve_pulse !== 1'b0) begin n_err++; $display("FAIL pre_serve got=%0d/%0d/%0b exp=1/1/0", state, countdown, serve_pulse); end
        cyc(1'b1, 2'b00);
        n_cmp++; if (state !== 3'd2 || serve_pulse !== 1'b1 || countdown !== 8'd0) begin n_err++; $display("FAIL serve_edge got=%0d/%0b/%0d exp=2/1/0", state, serve_pulse, countdown); end
        n_cmp++; if (ball_enable !== 1'b1) begin n_err++; $display("FAIL ball_en got=%0b exp=1", ball_enable); end
        cyc(1'b0, 2'b00);
        n_cmp++; if (serve_pulse !== 1'b0 || state !== 3'd2) begin n_err++; $display("FAIL pulse_width got=%0b/%0d exp=0/2", serve_pulse, state); end
        cyc(1'b1, 2'b10);
        n_cmp++; if (score_left !== 8'd1 || state !== 3'd3 || countdown !== 8'd30 || serve_dir !== 1'b1) begin n_err++; $display("FAIL left_point got=%0d/%0d/%0d/%0b exp=1/3/30/1", score_left, state, countdown, serve_dir); end
        n_cmp++; if (ball_enable !== 1'b0) begin n_err++; $display("FAIL ball_en_point got=%0b exp=0", ball_enable); end
        cyc(1'b1, 2'b00);
        n_cmp++; if (countdown !== 8'd29) begin n_err++; $display("FAIL hold_dec got=%0d exp=29", countdown); end
        for (int i = 0; i < 29; i++) cyc(1'b1, 2'b00);
        n_cmp++; if (state !== 3'd1 || countdown !== 8'd60) begin n_err++; $display("FAIL hold_done got=%0d/%0d exp=1/60", state, countdown); end
        serve();
        cyc(1'b0, 2'b01);
        n_cmp++; if (score_right !== 8'd1 || serve_dir !== 1'b0 || state !== 3'd3) begin n_err++; $display("FAIL right_point got=%0d/%0b/%0d exp=1/0/3", score_right, serve_dir, state); end
    endtask

    task automatic test_deuce();
        do_reset();
        do_start();
        for (int i = 0; i < 10; i++) begin
            play_point(2'b10);
            play_point(2'b01);
        end
        n_cmp++; if (score_left !== 8'd10 || score_right !== 8'd10 || state !== 3'd1) begin n_err++; $display("FAIL deuce_10 got=%0d:%0d/%0d exp=10:10/1", score_left, score_right, state); end
        play_point(2'b10);
        n_cmp++; if (score_left !== 8'd11 || state !== 3'd1 || countdown !== 8'd60) begin n_err++; $display("FAIL adv_11_10 got=%0d/%0d/%0d exp=11/1/60", score_left, state, countdown); end
        play_point(2'b01);
        play_point(2'b10);
        n_cmp++; if (score_left !== 8'd12 || score_right !== 8'd11 || state !== 3'd1) begin n_err++; $display("FAIL adv_12_11 got=%0d:%0d/%0d exp=12:11/1", score_left, score_right, state); end
        serve();
        cyc(1'b0, 2'b10);
        for (int i = 0; i < 29; i++) cyc(1'b1, 2'b00);
        n_cmp++; if (state !== 3'd3 || countdown !== 8'd1 || winner_valid !== 1'b0) begin n_err++; $display("FAIL win_pre got=%0d/%0d/%0b exp=3/1/0", state, countdown, winner_valid); end
        cyc(1'b1, 2'b00);
        n_cmp++; if (state !== 3'd4 || winner !== 1'b1 || winner_valid !== 1'b1 || countdown !== 8'd0) begin n_err++; $display("FAIL game_over got=%0d/%0b/%0b/%0d exp=4/1/1/0", state, winner, winner_valid, countdown); end
        cyc(1'b1, 2'b10);
        n_cmp++; if (score_left !== 8'd13 || score_right !== 8'd11 || state !== 3'd4) begin n_err++; $display("FAIL go_hold got=%0d:%0d/%0d exp=13:11/4", score_left, score_right, state); end
        do_start();
        n_cmp++; if (state !== 3'd1 || score_left !== 8'd0 || score_right !== 8'd0 || winner_valid !== 1'b0 || serve_dir !== 1'b1 || countdown !== 8'd60) begin n_err++; $display("FAIL restart got=%0d/%0d:%0d/%0b/%0b/%0d exp=1/0:0/0/1/60", state, score_left, score_right, winner_valid, serve_dir, countdown); end
    endtask

    task automatic test_let();
        do_reset();
        do_start();
        for (int i = 0; i < 4; i++) begin
            play_point(2'b10);
            play_point(2'b01);
        end
        serve();
        cyc(1'b0, 2'b11);
        n_cmp++; if (score_left !== 8'd4 || score_right !== 8'd4 || state !== 3'd3 || serve_dir !== 1'b0 || countdown !== 8'd30) begin n_err++; $display("FAIL let got=%0d:%0d/%0d/%0b/%0d exp=4:4/3/0/30", score_left, score_right, state, serve_dir, countdown); end
        cyc(1'b1, 2'b10);
        n_cmp++; if (score_left !== 8'd4 || countdown !== 8'd29 || state !== 3'd3) begin n_err++; $display("FAIL evt_in_point got=%0d/%0d/%0d exp=4/29/3", score_left, countdown, state); end
        for (int i = 0; i < 29; i++) cyc(1'b1, 2'b00);
        cyc(1'b0, 2'b01);
        n_cmp++; if (score_right !== 8'd4 || state !== 3'd1 || countdown !== 8'd60) begin n_err++; $display("FAIL evt_in_serve got=%0d/%0d/%0d exp=4/1/60", score_right, state, countdown); end
        do_start();
        n_cmp++; if (state !== 3'd1 || countdown !== 8'd60 || score_left !== 8'd4) begin n_err++; $display("FAIL start_in_serve got=%0d/%0d/%0d exp=1/60/4", state, countdown, score_left); end
    endtask

    task automatic test_pause();
        do_reset();
        do_start();
        for (int i = 0; i < 40; i++) cyc(1'b1, 2'b00);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b1, 2'b00);
        n_cmp++; if (countdown !== 8'd20 || state !== 3'd1 || ball_enable !== 1'b0) begin n_err++; $display("FAIL pause_hold got=%0d/%0d/%0b exp=20/1/0", countdown, state, ball_enable); end
        pause = 1'b0;
        cyc(1'b1, 2'b00);
        n_cmp++; if (countdown !== 8'd19) begin n_err++; $display("FAIL pause_resume got=%0d exp=19", countdown); end
        for (int i = 0; i < 19; i++) cyc(1'b1, 2'b00);
        pause = 1'b1;
        #1;
        n_cmp++; if (state !== 3'd2 || ball_enable !== 1'b0) begin n_err++; $display("FAIL pause_rally got=%0d/%0b exp=2/0", state, ball_enable); end
        cyc(1'b0, 2'b10);
        n_cmp++; if (score_left !== 8'd0 || state !== 3'd2) begin n_err++; $display("FAIL pause_evt got=%0d/%0d exp=0/2", score_left, state); end
        pause = 1'b0;
        #1;
        n_cmp++; if (ball_enable !== 1'b1) begin n_err++; $display("FAIL unpause_rally got=%0b exp=1", ball_enable); end
    endtask

    task automatic test_reset_mid_rally();
        do_reset();
        do_start();
        play_point(2'b10);
        play_point(2'b10);
        play_point(2'b10);
        play_point(2'b01);
        play_point(2'b01);
        serve();
        n_cmp++; if (state !== 3'd2 || score_left !== 8'd3 || score_right !== 8'd2) begin n_err++; $display("FAIL mid_rally got=%0d/%0d:%0d exp=2/3:2", state, score_left, score_right); end
        do_reset();
        n_cmp++; if (state !== 3'd0 || score_left !== 8'd0 || score_right !== 8'd0 || ball_enable !== 1'b0 || countdown !== 8'd0) begin n_err++; $display("FAIL rst_mid got=%0d/%0d:%0d/%0b/%0d exp=0/0:0/0/0", state, score_left, score_right, ball_enable, countdown); end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_l;
        do_reset();
        do_start();
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            play_point(2'b10);
            exp_l = (i < 15) ? 4'(i + 1) : 4'd15;
            n_cmp++; if (score_left2 !== exp_l || state2 !== 3'd1) begin n_err++; $display("FAIL sat_pt%0d got=%0d/%0d exp=%0d/1", i, score_left2, state2, exp_l); end
        end
        start = 1'b0;
        n_cmp++; if (winner_valid2 !== 1'b0 || score_right2 !== 4'd0) begin n_err++; $display("FAIL sat_end got=%0b/%0d exp=0/0", winner_valid2, score_right2); end
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        score_evt  = 2'b00;
        test_reset();
        test_serve_and_point();
        test_deuce();
        test_let();
        test_pause();
        test_reset_mid_rally();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
